// File: rtl/hv_mode_ctrl.sv
// HV-side mode controller: state sequencing, per-error glitch filters, efuse load retry and BIST timeout.
// Optional state-register parity checking is enabled by defining HV_CTRL_ST_PARITY_EN.
module hv_mode_ctrl #(
   parameter int ERR_NUM         = 12,
   parameter int FLT_NUM         = 4,
   parameter int EFUSE_DLY_NUM   = 16,
   parameter int EFUSE_TMO_NUM   = 256,
   parameter int EFUSE_RETRY_MAX = 3,
   parameter int BIST_TMO_NUM    = 1024,
   parameter int ST_W            = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_pwr_on,
   input  logic               i_io_test_mode,
   input  logic               i_io_fsiso,
   input  logic               i_fsiso_en,
   input  logic [ERR_NUM-1:0] i_err,
   input  logic [ERR_NUM-1:0] i_err_kill_msk,
   input  logic               i_reg_nml_en,
   input  logic               i_reg_cfg_en,
   input  logic               i_reg_bist_en,
   input  logic               i_reg_rst_en,
   input  logic               i_reg_efuse_vld,
   input  logic               i_efuse_load_done,
   input  logic               i_bist_done,
   output logic               o_efuse_load_req,
   output logic               o_pwm_en,
   output logic               o_spi_en,
   output logic               o_owt_com_en,
   output logic               o_wdg_scan_en,
   output logic               o_cfg_st_reg_en,
   output logic               o_test_st_reg_en,
   output logic               o_bist_en,
   output logic               o_intb_n,
   output logic [ERR_NUM-1:0] o_err_flt,
   output logic               o_efuse_fail,
   output logic               o_bist_tmo,
   output logic               o_st_par_err,
   output logic [ST_W-1:0]    o_cur_st
);

   localparam int FLT_W  = $clog2(FLT_NUM + 1);
   localparam int DLY_W  = $clog2(EFUSE_DLY_NUM + 1);
   localparam int TMO_W  = $clog2(EFUSE_TMO_NUM + 1);
   localparam int ATT_W  = $clog2(EFUSE_RETRY_MAX + 1);
   localparam int BIST_W = $clog2(BIST_TMO_NUM + 1);

   typedef enum logic [ST_W-1:0] {
      ST_PWR_DWN = ST_W'(0),
      ST_WAIT    = ST_W'(1),
      ST_TEST    = ST_W'(2),
      ST_NML     = ST_W'(3),
      ST_FSISO   = ST_W'(4),
      ST_FAULT   = ST_W'(5),
      ST_CFG     = ST_W'(6),
      ST_RST     = ST_W'(7),
      ST_BIST    = ST_W'(8)
   } st_e;

   st_e                cur_st_q, nxt_st;
   logic [ERR_NUM-1:0] err_flt_q, err_flt_d;
   logic [FLT_W-1:0]   flt_cnt_q [ERR_NUM];
   logic [FLT_W-1:0]   flt_cnt_d [ERR_NUM];
   logic               req_q, req_d, fail_q, fail_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [ATT_W-1:0]   att_q, att_d;
   logic [BIST_W-1:0]  bist_cnt_q, bist_cnt_d;
   logic               bist_tmo_q, bist_tmo_d;
   logic               pwm_q, spi_q, owt_q, wdg_q, cfg_reg_q, test_reg_q, bist_en_q, intb_n_q;
   logic               pwm_d, spi_d, owt_d, wdg_d, cfg_reg_d, test_reg_d, bist_en_d, intb_n_d;
   logic               fsiso, err_any, kill, err_any_d, kill_d, efuse_active, par_bad;

   assign fsiso        = i_io_fsiso & i_fsiso_en;
   assign err_any      = |err_flt_q;
   assign kill         = |(err_flt_q & i_err_kill_msk);
   assign err_any_d    = |err_flt_d;
   assign kill_d       = |(err_flt_d & i_err_kill_msk);
   assign efuse_active = (cur_st_q == ST_WAIT) & ~i_io_test_mode & ~i_reg_efuse_vld;

   // Filter counter only runs while the raw input disagrees with the filtered value.
   always_comb begin
      for (int i = 0; i < ERR_NUM; i++) begin
         flt_cnt_d[i] = '0;
         err_flt_d[i] = err_flt_q[i];
         if (i_err[i] != err_flt_q[i]) begin
            if (flt_cnt_q[i] == FLT_W'(FLT_NUM - 1)) err_flt_d[i] = i_err[i];
            else                                     flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      nxt_st = cur_st_q;
      case (cur_st_q)
         ST_PWR_DWN: if (i_pwr_on) nxt_st = ST_WAIT;
         ST_WAIT: begin
            if (i_io_test_mode | fail_q)                   nxt_st = ST_TEST;
            else if (~kill & i_reg_nml_en & i_reg_efuse_vld) nxt_st = ST_NML;
         end
         ST_TEST:  if (~i_io_test_mode & i_reg_efuse_vld) nxt_st = ST_WAIT;
         ST_NML: begin
            if (i_reg_cfg_en) nxt_st = ST_CFG;
            else if (err_any) nxt_st = ST_FAULT;
         end
         ST_FAULT: begin
            if (i_reg_cfg_en)  nxt_st = ST_CFG;
            else if (~err_any) nxt_st = ST_NML;
         end
         ST_FSISO: if (~fsiso) nxt_st = ST_WAIT;
         ST_CFG: begin
            if (i_reg_rst_en)                          nxt_st = ST_RST;
            else if (err_any & ~kill & ~i_reg_cfg_en)  nxt_st = ST_FAULT;
            else if (~err_any & i_reg_bist_en)         nxt_st = ST_BIST;
            else if (~err_any & ~i_reg_cfg_en)         nxt_st = ST_NML;
         end
         ST_RST:  if (~i_reg_rst_en) nxt_st = ST_WAIT;
         ST_BIST: if (i_reg_cfg_en & ~i_reg_bist_en) nxt_st = ST_CFG;
         default: nxt_st = ST_PWR_DWN;
      endcase
      if (fsiso && cur_st_q != ST_PWR_DWN) nxt_st = ST_FSISO;
      if (~i_pwr_on)                       nxt_st = ST_PWR_DWN;
      if (par_bad)                         nxt_st = ST_PWR_DWN;
   end

   // Efuse load: delay, request, timeout/retry; a done pulse restarts the delay.
   always_comb begin
      req_d  = req_q;
      dly_d  = dly_q;
      tmo_d  = tmo_q;
      att_d  = att_q;
      fail_d = fail_q;
      if (cur_st_q != ST_WAIT) begin
         req_d = 1'b0;
         dly_d = '0;
         tmo_d = '0;
      end else if (efuse_active & ~fail_q) begin
         if (req_q) begin
            if (i_efuse_load_done) begin
               req_d = 1'b0;
               dly_d = '0;
               tmo_d = '0;
               att_d = '0;
            end else if (tmo_q == TMO_W'(EFUSE_TMO_NUM - 1)) begin
               req_d = 1'b0;
               tmo_d = '0;
               if (att_q == ATT_W'(EFUSE_RETRY_MAX - 1)) begin
                  att_d  = ATT_W'(EFUSE_RETRY_MAX);
                  fail_d = 1'b1;
               end else begin
                  att_d = att_q + 1'b1;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end else if (dly_q == DLY_W'(EFUSE_DLY_NUM - 1)) begin
            req_d = 1'b1;
         end else begin
            dly_d = dly_q + 1'b1;
         end
      end else begin
         req_d = 1'b0;
      end
      if (nxt_st == ST_PWR_DWN) begin
         att_d  = '0;
         fail_d = 1'b0;
      end
   end

   always_comb begin
      bist_cnt_d = bist_cnt_q;
      bist_tmo_d = bist_tmo_q;
      if (nxt_st == ST_BIST && cur_st_q != ST_BIST) begin
         bist_cnt_d = '0;
         bist_tmo_d = 1'b0;
      end else if (cur_st_q == ST_BIST && ~i_bist_done) begin
         if (bist_cnt_q == BIST_W'(BIST_TMO_NUM - 1)) bist_tmo_d = 1'b1;
         else                                          bist_cnt_d = bist_cnt_q + 1'b1;
      end
      if (nxt_st == ST_PWR_DWN) bist_tmo_d = 1'b0;
   end

   // Enables are decoded from the next state so they line up with o_cur_st.
   always_comb begin
      pwm_d      = (nxt_st == ST_NML) | ((nxt_st == ST_FAULT) & ~kill_d);
      spi_d      = (nxt_st != ST_PWR_DWN);
      owt_d      = (nxt_st == ST_NML) | (nxt_st == ST_FAULT);
      wdg_d      = owt_d;
      cfg_reg_d  = (nxt_st == ST_CFG);
      test_reg_d = (nxt_st == ST_TEST);
      bist_en_d  = (nxt_st == ST_BIST);
      case (nxt_st)
         ST_NML, ST_TEST: intb_n_d = 1'b1;
         ST_CFG:          intb_n_d = ~err_any_d;
         ST_BIST:         intb_n_d = i_bist_done & ~bist_tmo_d;
         default:         intb_n_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cur_st_q   <= ST_PWR_DWN;
         err_flt_q  <= '0;
         for (int i = 0; i < ERR_NUM; i++) flt_cnt_q[i] <= '0;
         req_q      <= 1'b0;
         fail_q     <= 1'b0;
         dly_q      <= '0;
         tmo_q      <= '0;
         att_q      <= '0;
         bist_cnt_q <= '0;
         bist_tmo_q <= 1'b0;
         pwm_q      <= 1'b0;
         spi_q      <= 1'b0;
         owt_q      <= 1'b0;
         wdg_q      <= 1'b0;
         cfg_reg_q  <= 1'b0;
         test_reg_q <= 1'b0;
         bist_en_q  <= 1'b0;
         intb_n_q   <= 1'b0;
      end else begin
         cur_st_q   <= nxt_st;
         err_flt_q  <= err_flt_d;
         for (int i = 0; i < ERR_NUM; i++) flt_cnt_q[i] <= flt_cnt_d[i];
         req_q      <= req_d;
         fail_q     <= fail_d;
         dly_q      <= dly_d;
         tmo_q      <= tmo_d;
         att_q      <= att_d;
         bist_cnt_q <= bist_cnt_d;
         bist_tmo_q <= bist_tmo_d;
         pwm_q      <= pwm_d;
         spi_q      <= spi_d;
         owt_q      <= owt_d;
         wdg_q      <= wdg_d;
         cfg_reg_q  <= cfg_reg_d;
         test_reg_q <= test_reg_d;
         bist_en_q  <= bist_en_d;
         intb_n_q   <= intb_n_d;
      end
   end

`ifdef HV_CTRL_ST_PARITY_EN
   logic par_q, par_err_q;

   assign par_bad = (^cur_st_q) != par_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         par_q     <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         par_q     <= ^nxt_st;
         par_err_q <= par_err_q | par_bad;
      end
   end

   assign o_st_par_err = par_err_q;
`else
   assign par_bad      = 1'b0;
   assign o_st_par_err = 1'b0;
`endif

   assign o_cur_st         = cur_st_q;
   assign o_err_flt        = err_flt_q;
   assign o_efuse_load_req = req_q;
   assign o_efuse_fail     = fail_q;
   assign o_bist_tmo       = bist_tmo_q;
   assign o_pwm_en         = pwm_q;
   assign o_spi_en         = spi_q;
   assign o_owt_com_en     = owt_q;
   assign o_wdg_scan_en    = wdg_q;
   assign o_cfg_st_reg_en  = cfg_reg_q;
   assign o_test_st_reg_en = test_reg_q;
   assign o_bist_en        = bist_en_q;
   assign o_intb_n         = intb_n_q;

endmodule

// File: tb/tb_hv_mode_ctrl.sv
// Directed bench for hv_mode_ctrl: efuse retry, error filter/FAULT, CFG/BIST timeout, FSISO, power-down, reset.
module tb_hv_mode_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pwr_on = 1'b0, test_mode = 1'b0, io_fsiso = 1'b0, fsiso_en = 1'b0;
   logic [11:0] err = '0, kill_msk = '0;
   logic        nml_en = 1'b0, cfg_en = 1'b0, bist_en = 1'b0, rst_en = 1'b0;
   logic        efuse_vld = 1'b0, load_done = 1'b0, bist_done = 1'b0;
   logic        load_req, pwm_en, spi_en, owt_en, wdg_en, cfg_reg_en, test_reg_en, bist_en_o, intb_n;
   logic [11:0] err_flt;
   logic        efuse_fail, bist_tmo, st_par_err;
   logic [3:0]  cur_st;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hv_mode_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pwr_on(pwr_on), .i_io_test_mode(test_mode),
      .i_io_fsiso(io_fsiso), .i_fsiso_en(fsiso_en), .i_err(err), .i_err_kill_msk(kill_msk),
      .i_reg_nml_en(nml_en), .i_reg_cfg_en(cfg_en), .i_reg_bist_en(bist_en), .i_reg_rst_en(rst_en),
      .i_reg_efuse_vld(efuse_vld), .i_efuse_load_done(load_done), .i_bist_done(bist_done),
      .o_efuse_load_req(load_req), .o_pwm_en(pwm_en), .o_spi_en(spi_en), .o_owt_com_en(owt_en),
      .o_wdg_scan_en(wdg_en), .o_cfg_st_reg_en(cfg_reg_en), .o_test_st_reg_en(test_reg_en),
      .o_bist_en(bist_en_o), .o_intb_n(intb_n), .o_err_flt(err_flt), .o_efuse_fail(efuse_fail),
      .o_bist_tmo(bist_tmo), .o_st_par_err(st_par_err), .o_cur_st(cur_st)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tick(2);
      check("rst_st", cur_st, 0);
      check("rst_intb", intb_n, 0);
      check("rst_spi", spi_en, 0);
      check("rst_flt", err_flt, 0);
      check("rst_req", load_req, 0);
      check("rst_fail", efuse_fail, 0);

      // efuse request after delay, done pulse
      rst_n = 1'b1;
      pwr_on = 1'b1;
      tick(1);
      check("wait_st", cur_st, 1);
      check("wait_spi", spi_en, 1);
      check("wait_intb", intb_n, 0);
      tick(15);
      check("req_early", load_req, 0);
      tick(1);
      check("req_rise", load_req, 1);
      load_done = 1'b1;
      tick(1);
      load_done = 1'b0;
      check("req_done", load_req, 0);
      check("done_st", cur_st, 1);

      // three timed-out attempts
      tick(15);
      check("req2_early", load_req, 0);
      tick(1);
      check("req2_rise", load_req, 1);
      tick(255);
      check("att1_hold", load_req, 1);
      tick(1);
      check("att1_gap", load_req, 0);
      check("att1_nofail", efuse_fail, 0);
      tick(1);
      check("att2_rise", load_req, 1);
      tick(256);
      check("att2_gap", load_req, 0);
      tick(1);
      check("att3_rise", load_req, 1);
      tick(256);
      check("att3_req", load_req, 0);
      check("efuse_fail", efuse_fail, 1);
      tick(1);
      check("test_st", cur_st, 2);
      check("test_reg", test_reg_en, 1);
      check("test_intb", intb_n, 1);

      // power-down clears the failure
      pwr_on = 1'b0;
      tick(1);
      check("pd_st", cur_st, 0);
      check("pd_spi", spi_en, 0);
      check("pd_intb", intb_n, 0);
      check("pd_fail", efuse_fail, 0);

      // normal mode and error filter
      pwr_on = 1'b1;
      efuse_vld = 1'b1;
      nml_en = 1'b1;
      tick(1);
      check("wait2_st", cur_st, 1);
      tick(1);
      check("nml_st", cur_st, 3);
      check("nml_pwm", pwm_en, 1);
      check("nml_owt", owt_en, 1);
      check("nml_wdg", wdg_en, 1);
      check("nml_intb", intb_n, 1);
      err = 12'h001;
      tick(3);
      check("flt3_flt", err_flt, 0);
      check("flt3_st", cur_st, 3);
      err = 12'h000;
      tick(1);
      err = 12'h001;
      tick(3);
      check("flt_clr", err_flt, 0);
      tick(1);
      check("flt4_flt", err_flt, 12'h001);
      check("flt4_st", cur_st, 3);
      tick(1);
      check("fault_st", cur_st, 5);
      check("fault_intb", intb_n, 0);
      check("fault_pwm", pwm_en, 1);
      kill_msk = 12'h001;
      tick(1);
      check("kill_pwm", pwm_en, 0);
      check("kill_st", cur_st, 5);
      err = 12'h000;
      tick(3);
      check("fall3_flt", err_flt, 12'h001);
      tick(1);
      check("fall4_flt", err_flt, 0);
      tick(1);
      check("back_nml", cur_st, 3);
      check("back_pwm", pwm_en, 1);

      // CFG and BIST timeout
      cfg_en = 1'b1;
      tick(1);
      check("cfg_st", cur_st, 6);
      check("cfg_reg", cfg_reg_en, 1);
      check("cfg_pwm", pwm_en, 0);
      check("cfg_intb", intb_n, 1);
      bist_en = 1'b1;
      tick(1);
      check("bist_st", cur_st, 8);
      check("bist_en", bist_en_o, 1);
      check("bist_intb", intb_n, 0);
      tick(1000);
      check("bist_tmo_early", bist_tmo, 0);
      tick(30);
      check("bist_tmo", bist_tmo, 1);
      check("bist_tmo_intb", intb_n, 0);
      bist_done = 1'b1;
      tick(1);
      check("bist_done_intb", intb_n, 0);
      bist_en = 1'b0;
      tick(1);
      check("bist_cfg_st", cur_st, 6);
      check("bist_tmo_sticky", bist_tmo, 1);

      // FSISO and power-down
      fsiso_en = 1'b1;
      io_fsiso = 1'b1;
      tick(1);
      check("fsiso_st", cur_st, 4);
      check("fsiso_pwm", pwm_en, 0);
      check("fsiso_intb", intb_n, 0);
      io_fsiso = 1'b0;
      tick(1);
      check("fsiso_exit", cur_st, 1);
      pwr_on = 1'b0;
      tick(1);
      check("pd2_st", cur_st, 0);
      check("pd2_spi", spi_en, 0);
      check("pd2_tmo", bist_tmo, 0);
      check("par_err_idle", st_par_err, 0);

`ifdef HV_CTRL_ST_PARITY_EN
      pwr_on = 1'b1;
      tick(1);
      check("par_wait", cur_st, 1);
      force dut.par_q = 1'b0;
      #1;
      release dut.par_q;
      tick(1);
      check("par_st", cur_st, 0);
      check("par_err", st_par_err, 1);
      tick(2);
      check("par_sticky", st_par_err, 1);
`else
      pwr_on = 1'b1;
`endif

      // asynchronous reset mid-operation
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_st", cur_st, 0);
      check("arst_spi", spi_en, 0);
      check("arst_par", st_par_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
